// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: hazard FSM states, opcode constants
// and small elaboration-time helpers.
package rv32i_pkg;

  typedef enum logic [1:0] {
    HZ_BOOT  = 2'b00,
    HZ_RUN   = 2'b01,
    HZ_LU    = 2'b10,
    HZ_FLUSH = 2'b11
  } hz_state_t;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Used for the hazard performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Front-end hazard control: boot hold, load-use stall,
// external freeze and redirect flush, with perf counters.
import rv32i_pkg::*;

module hazard_ctrl_unit #(
  parameter int BOOT_CYCLES  = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_mem_read,
  input  logic             PC_redirect,
  input  logic             ext_stall,
  output logic             EN_PC,
  output logic             IF_ID_En,
  output logic             NOP_Ins,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       hz_state
);

  localparam int MAXC =
    max3(BOOT_CYCLES, LOAD_LAT, FLUSH_CYCLES);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] BOOT_LAST =
    CW'(BOOT_CYCLES - 1);
  localparam logic [CW-1:0] LU_LAST =
    CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FL_LAST =
    CW'(FLUSH_CYCLES - 1);

  hz_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lu;
  logic          hit1, hit2;

  assign hit1 = ID_uses_rs1 && (ID_rs1 == EX_rd);
  assign hit2 = ID_uses_rs2 && (ID_rs2 == EX_rd);
  assign lu = EX_mem_read && (EX_rd != 5'd0)
           && (hit1 || hit2);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= HZ_BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    EN_PC       = 1'b1;
    IF_ID_En    = 1'b1;
    NOP_Ins     = 1'b0;
    if_id_flush = 1'b0;
    if (state == HZ_BOOT) begin
      EN_PC       = 1'b0;
      IF_ID_En    = 1'b0;
      if_id_flush = 1'b1;
      if (cnt == BOOT_LAST) begin
        state_nx = HZ_RUN;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end else if (PC_redirect) begin
      // redirect also drops any pending load-use stall
      if_id_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nx = HZ_FLUSH;
        cnt_nx   = CW'(1);
      end else begin
        state_nx = HZ_RUN;
        cnt_nx   = '0;
      end
    end else if (ext_stall) begin
      EN_PC    = 1'b0;
      IF_ID_En = 1'b0;
      NOP_Ins  = 1'b1;
    end else begin
      unique case (state)
        HZ_RUN: begin
          if (lu) begin
            EN_PC    = 1'b0;
            IF_ID_En = 1'b0;
            NOP_Ins  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nx = HZ_LU;
              cnt_nx   = CW'(1);
            end
          end
        end
        HZ_LU: begin
          EN_PC    = 1'b0;
          IF_ID_En = 1'b0;
          NOP_Ins  = 1'b1;
          if (cnt == LU_LAST) begin
            state_nx = HZ_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        HZ_FLUSH: begin
          if_id_flush = 1'b1;
          if (cnt == FL_LAST) begin
            state_nx = HZ_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        HZ_BOOT: begin
        end
      endcase
    end
  end

  assign hz_state = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (rst_n),
    .inc   (NOP_Ins),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (rst_n),
    .inc   (if_id_flush && (state != HZ_BOOT)),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomised + directed bench for hazard_ctrl_unit; two
// parameterisations checked against a cycle-budget model.
module tb_hazard_ctrl_unit;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
  logic       ID_uses_rs1 = 0, ID_uses_rs2 = 0;
  logic       EX_mem_read = 0, PC_redirect = 0;
  logic       ext_stall = 0;

  logic        en0, ifid0, nop0, fl0;
  logic        en1, ifid1, nop1, fl1;
  logic [1:0]  hz0, hz1;
  logic [31:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  logic [5:0]  obs [2];
  logic [63:0] obs_sc [2];
  logic [63:0] obs_fc [2];

  int checks = 0;
  int errors = 0;

  // per-instance parameters: B, L, F, counter ceiling
  int     pb [2] = '{2, 2};
  int     pl [2] = '{1, 3};
  int     pf [2] = '{1, 2};
  longint pmax [2] = '{64'hFFFF_FFFF, 64'd15};

  // model: remaining cycles in each hold condition
  int     boot_left [2];
  int     stall_left [2];
  int     flush_left [2];
  longint m_sc [2];
  longint m_fc [2];

  always #5 CLK = ~CLK;

  hazard_ctrl_unit #(
    .BOOT_CYCLES(2), .LOAD_LAT(1),
    .FLUSH_CYCLES(1), .CNT_W(32)
  ) u0 (
    .CLK(CLK), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1),
    .ID_uses_rs2(ID_uses_rs2),
    .EX_rd(EX_rd), .EX_mem_read(EX_mem_read),
    .PC_redirect(PC_redirect),
    .ext_stall(ext_stall),
    .EN_PC(en0), .IF_ID_En(ifid0),
    .NOP_Ins(nop0), .if_id_flush(fl0),
    .stall_cnt(sc0), .flush_cnt(fc0),
    .hz_state(hz0)
  );

  hazard_ctrl_unit #(
    .BOOT_CYCLES(2), .LOAD_LAT(3),
    .FLUSH_CYCLES(2), .CNT_W(4)
  ) u1 (
    .CLK(CLK), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1),
    .ID_uses_rs2(ID_uses_rs2),
    .EX_rd(EX_rd), .EX_mem_read(EX_mem_read),
    .PC_redirect(PC_redirect),
    .ext_stall(ext_stall),
    .EN_PC(en1), .IF_ID_En(ifid1),
    .NOP_Ins(nop1), .if_id_flush(fl1),
    .stall_cnt(sc1), .flush_cnt(fc1),
    .hz_state(hz1)
  );

  assign obs[0] = {en0, ifid0, nop0, fl0, hz0};
  assign obs[1] = {en1, ifid1, nop1, fl1, hz1};
  assign obs_sc[0] = 64'(sc0);
  assign obs_sc[1] = 64'(sc1);
  assign obs_fc[0] = 64'(fc0);
  assign obs_fc[1] = 64'(fc1);

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit load_use();
    bit h1, h2;
    h1 = ID_uses_rs1 && ID_rs1 == EX_rd;
    h2 = ID_uses_rs2 && ID_rs2 == EX_rd;
    return EX_mem_read && EX_rd != 0 && (h1 || h2);
  endfunction

  // expected {EN_PC, IF_ID_En, NOP_Ins, if_id_flush, hz}
  function automatic logic [5:0] expect_out(input int i);
    logic [1:0] hz;
    if (boot_left[i] > 0) return 6'b0001_00;
    if (stall_left[i] > 0) hz = 2'd2;
    else if (flush_left[i] > 0) hz = 2'd3;
    else hz = 2'd1;
    if (PC_redirect) return {4'b1101, hz};
    if (ext_stall) return {4'b0010, hz};
    if (stall_left[i] > 0) return {4'b0010, hz};
    if (flush_left[i] > 0) return {4'b1101, hz};
    if (load_use()) return {4'b0010, hz};
    return {4'b1100, hz};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      boot_left[i] = pb[i];
      stall_left[i] = 0;
      flush_left[i] = 0;
      m_sc[i] = 0;
      m_fc[i] = 0;
    end
  endtask

  task automatic model_clock();
    logic [5:0] e;
    for (int i = 0; i < 2; i++) begin
      e = expect_out(i);
      if (e[3] && m_sc[i] < pmax[i]) m_sc[i]++;
      if (e[2] && boot_left[i] == 0
          && m_fc[i] < pmax[i]) m_fc[i]++;
      if (boot_left[i] > 0) boot_left[i]--;
      else if (PC_redirect) begin
        stall_left[i] = 0;
        flush_left[i] = pf[i] - 1;
      end else if (ext_stall) begin
      end else if (stall_left[i] > 0) stall_left[i]--;
      else if (flush_left[i] > 0) flush_left[i]--;
      else if (load_use()) stall_left[i] = pl[i] - 1;
    end
  endtask

  task automatic set_in(input bit mr, input logic [4:0] rd,
                        input logic [4:0] r1, input bit u1,
                        input logic [4:0] r2, input bit u2,
                        input bit rdr, input bit ext);
    EX_mem_read = mr; EX_rd = rd;
    ID_rs1 = r1; ID_uses_rs1 = u1;
    ID_rs2 = r2; ID_uses_rs2 = u2;
    PC_redirect = rdr; ext_stall = ext;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // entered at posedge+1; samples mid-cycle, then clocks
  task automatic step(input string tag);
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.out%0d", tag, i),
            64'(obs[i]), 64'(expect_out(i)));
      check($sformatf("%s.scnt%0d", tag, i),
            obs_sc[i], 64'(m_sc[i]));
      check($sformatf("%s.fcnt%0d", tag, i),
            obs_fc[i], 64'(m_fc[i]));
    end
    @(posedge CLK);
    if (rst_n) model_clock();
    #1;
  endtask

  // asynchronous reset pulse taken mid-cycle
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, ".hz0"}, 64'(hz0), 64'd0);
    check({tag, ".hz1"}, 64'(hz1), 64'd0);
    check({tag, ".sc1"}, 64'(sc1), 64'd0);
    check({tag, ".fc0"}, 64'(fc0), 64'd0);
    model_reset();
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge CLK);
    #1;
    check("rst.hz", 64'(hz1), 64'd0);
    check("rst.fl", 64'(fl1), 64'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step("boot");

    set_in(1, 5, 0, 0, 5, 1, 0, 0);
    step("lu_rs2");
    idle();
    for (int k = 0; k < 3; k++) step("lu_after");
    set_in(1, 0, 0, 1, 0, 1, 0, 0);
    step("lu_x0");

    set_in(1, 7, 7, 1, 0, 0, 0, 0);
    step("lu3_a");
    idle();
    for (int k = 0; k < 3; k++) step("lu3_b");
    set_in(1, 7, 7, 1, 0, 0, 0, 0);
    step("abort_a");
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("abort_b");
    idle();
    for (int k = 0; k < 2; k++) step("abort_c");

    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    step("redir_ext");
    idle();
    for (int k = 0; k < 2; k++) step("redir_post");

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("fl_frz_a");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step("fl_frz_b");
    idle();
    for (int k = 0; k < 2; k++) step("fl_frz_c");

    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) step("sat");
    set_in(1, 3, 3, 1, 0, 0, 0, 0);
    step("rst_lu_a");
    idle();
    step("rst_lu_b");
    pulse_reset("arst");
    for (int k = 0; k < 3; k++) step("arst_boot");

    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 2) != 0,
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0)
        pulse_reset("rnd_rst");
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
